// File: rtl/instruction_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: instruction id,
// fetch fault metadata and the packed queue entry.
package instruction_queue_pkg;

    localparam int ID_W = 3;

    typedef logic [ID_W-1:0] id_t;

    localparam logic [4:0] INST_PAGE_FAULT = 5'd12;

    typedef struct packed {
        logic       ok;
        logic [4:0] error_code;
    } fetch_metadata_t;

    typedef struct packed {
        logic [31:0]     pc;
        id_t             id;
        logic [31:0]     instruction;
        fetch_metadata_t metadata;
    } iq_entry_t;

endpackage

// File: rtl/iq_lutram.sv
// Queue storage: DEPTH entries, one synchronous write port and one
// asynchronous read port (maps onto distributed/LUT RAM).
module iq_lutram
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  iq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output iq_entry_t                rdata
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// Fetch-to-decode decoupling queue with issue-credit accounting.
// Define IQUEUE_BYPASS_EN to let a completing fetch reach decode in the same cycle when empty.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fetch_issue,
    input  logic                     fetch_retire,
    input  logic                     fetch_complete,
    input  logic [31:0]              fetch_pc,
    input  id_t                      fetch_id,
    input  logic [31:0]              fetch_instruction,
    input  fetch_metadata_t          fetch_metadata,
    output logic                     issue_credit,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output iq_entry_t                dec_entry,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);
    localparam logic [RW-1:0] RES_MAX   = RW'(MAX_OUTSTANDING);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [RW-1:0] reserved;
    logic [CW:0]   load;
    logic          enq;
    logic          deq;
    iq_entry_t     fetch_entry;
    iq_entry_t     rd_data;

    assign fetch_entry = '{pc: fetch_pc, id: fetch_id, instruction: fetch_instruction,
                           metadata: fetch_metadata};

`ifdef IQUEUE_BYPASS_EN
    logic bypass_hit;

    // An empty queue forwards the completing fetch; it is only stored if decode stalls.
    assign bypass_hit = (count == '0) && fetch_complete && !flush;
    assign dec_valid  = (count != '0) || bypass_hit;
    assign dec_entry  = bypass_hit ? fetch_entry : rd_data;
    assign enq        = fetch_complete && !flush && !(bypass_hit && dec_ready);
    assign deq        = (count != '0) && dec_ready && !flush;
`else
    assign dec_valid  = (count != '0);
    assign dec_entry  = rd_data;
    assign enq        = fetch_complete && !flush;
    assign deq        = dec_valid && dec_ready && !flush;
`endif

    // Credit looks only at registered state, so fetch_issue never feeds back combinationally.
    assign load         = {1'b0, count} + {{(CW + 1 - RW){1'b0}}, reserved};
    assign issue_credit = (load < DEPTH_EXT);
    assign occupancy    = count;

    iq_lutram #(.DEPTH(DEPTH)) storage (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (fetch_entry),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            reserved <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + 1'b1;
                if (deq)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            // Flushed fetches still retire, so reservations survive a flush.
            case ({fetch_issue, fetch_retire})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: reserved <= reserved;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fetch_complete && !flush && count == FULL))
                else $error("instruction_queue: completion while queue full");
            assert (!(fetch_retire && !fetch_issue && reserved == '0))
                else $error("instruction_queue: reservation underflow");
            assert (!(fetch_issue && !fetch_retire && reserved == RES_MAX))
                else $error("instruction_queue: too many outstanding fetches");
        end
    end
`endif

endmodule
